// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline.
// Drives PC / IF-ID / ID-EX hold and flush, tracks the multi-cycle
// mult/div unit, and counts stall cycles for performance bring-up.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int REG_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt_dst,
  input  logic             ex_branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [1:0]       hz_state,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_MD_WAIT  = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_e;

  logic [7:0]  md_cnt;
  logic [15:0] stall_q;
  logic        busy;
  logic        lu;
  logic        mdh;
  logic        stall;
  logic        md_issue;
  hz_e         hz;

  assign busy = (md_cnt != 8'd0);

  // A load whose target is $zero never creates a dependency.
  assign lu = ex_mem_read && (ex_rt_dst != '0) &&
              ((id_uses_rs && (id_rs == ex_rt_dst)) ||
               (id_uses_rt && (id_rt == ex_rt_dst)));

  assign mdh   = busy && (id_md_start || id_md_read);
  assign stall = (lu || mdh) && !ex_branch_taken;

  // A mult/div squashed by a taken branch, or held by a stall, must not start.
  assign md_issue = id_md_start && !stall && !ex_branch_taken;

  // Hold/flush decode; reset forces everything quiet.
  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    hz         = HZ_RUN;
    if (!reset) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        hz         = HZ_FLUSH;
      end else if (stall) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
        hz         = lu ? HZ_LOAD_USE : HZ_MD_WAIT;
      end
    end
  end

  assign hz_state     = hz;
  assign md_busy      = !reset && busy;
  assign stall_cycles = reset ? 16'd0 : stall_q;

  // Mult/div occupancy: load the latency on issue, otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (reset)         md_cnt <= 8'd0;
    else if (md_issue) md_cnt <= 8'(MD_CYCLES);
    else if (busy)     md_cnt <= md_cnt - 8'd1;
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (reset)                             stall_q <= 16'd0;
    else if (pc_hold && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver pushes expected outputs
// computed from a cycle-numbered reference model; the monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int MD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt_dst;
  logic       id_uses_rs, id_uses_rt, id_md_start, id_md_read, ex_mem_read, ex_branch_taken;
  logic       pc_hold, ifid_hold, ifid_flush, idex_flush, md_busy;
  logic [1:0] hz_state;
  logic [15:0] stall_cycles;

  pipe_hazard_ctrl #(.MD_CYCLES(MD), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .ex_mem_read(ex_mem_read), .ex_rt_dst(ex_rt_dst),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .md_busy(md_busy), .hz_state(hz_state),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt, mds, mdr, emr;
    logic [4:0] erd;
    logic       br;
  } in_t;

  typedef struct packed {
    logic [3:0]  hf;      // pc_hold, ifid_hold, ifid_flush, idex_flush
    logic [1:0]  hz;
    logic        busy;
    logic [15:0] sc;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: mult/div occupancy is the last cycle number it stays busy.
  int          cyc = 0;
  int          busy_until = -1;
  int          scnt = 0;

  task automatic drive(input in_t v);
    exp_t e;
    bit lu, mdh, st, bsy;
    @(negedge clk);
    reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_md_start = v.mds; id_md_read = v.mdr; ex_mem_read = v.emr; ex_rt_dst = v.erd;
    ex_branch_taken = v.br;
    #1;
    e = '0;
    e.cyc = cyc;
    bsy = (cyc <= busy_until);
    if (v.rst) begin
      scnt = 0;
      busy_until = cyc;
    end else begin
      lu  = v.emr && v.erd != 0 && ((v.urs && v.rs == v.erd) || (v.urt && v.rt == v.erd));
      mdh = bsy && (v.mds || v.mdr);
      st  = (lu || mdh) && !v.br;
      e.busy = bsy;
      e.sc   = 16'(scnt);
      if (v.br)      begin e.hf = 4'b0011; e.hz = 2'd3; end
      else if (st)   begin e.hf = 4'b1101; e.hz = lu ? 2'd1 : 2'd2; end
      if (st && scnt < 65535) scnt++;
      if (v.mds && !st && !v.br) busy_until = cyc + MD;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic chk(input string name, input int c, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, want);
    end
  endtask

  // Monitor: outputs are settled 2 time units after the driving edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hold_flush", e.cyc, 16'({pc_hold, ifid_hold, ifid_flush, idex_flush}), 16'(e.hf));
      chk("hz_state",   e.cyc, 16'(hz_state), 16'(e.hz));
      chk("md_busy",    e.cyc, 16'(md_busy), 16'(e.busy));
      chk("stall_cycles", e.cyc, stall_cycles, e.sc);
    end
  end

  function automatic in_t idle();
    in_t v = '0;
    return v;
  endfunction

  initial begin
    in_t v;
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_md_start = 0; id_md_read = 0; ex_mem_read = 0; ex_rt_dst = '0; ex_branch_taken = 0;

    v = idle(); v.rst = 1; drive(v); drive(v);
    drive(idle());
    // load-use on rs, then $zero destination (no stall)
    v = idle(); v.emr = 1; v.erd = 8; v.urs = 1; v.rs = 8; drive(v);
    drive(idle());
    v = idle(); v.emr = 1; v.erd = 0; v.urs = 1; v.rs = 0; drive(v);
    v = idle(); v.emr = 1; v.erd = 9; v.urt = 1; v.rt = 9; drive(v);
    // mult then mflo: 4 stall cycles
    v = idle(); v.mds = 1; drive(v);
    v = idle(); v.mdr = 1; for (int i = 0; i < 6; i++) drive(v);
    // branch over load-use, with and without a squashed mult
    v = idle(); v.emr = 1; v.erd = 3; v.urs = 1; v.rs = 3; v.br = 1; drive(v);
    v.mds = 1; drive(v);
    v = idle(); v.mdr = 1; drive(v);
    // back-to-back mult
    v = idle(); v.mds = 1; for (int i = 0; i < 12; i++) drive(v);
    drive(idle()); drive(idle()); drive(idle()); drive(idle());
    // reset mid-mult, then mflo proceeds
    v = idle(); v.mds = 1; drive(v);
    drive(idle());
    v = idle(); v.rst = 1; drive(v);
    v = idle(); v.mdr = 1; drive(v); drive(v);

    // randomized traffic with narrow register range to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      v.rst = ($urandom_range(63) == 0);
      v.rs  = 5'($urandom_range(3)); v.rt = 5'($urandom_range(3));
      v.erd = 5'($urandom_range(3));
      v.urs = 1'($urandom); v.urt = 1'($urandom); v.emr = 1'($urandom);
      v.mds = ($urandom_range(3) == 0); v.mdr = ($urandom_range(3) == 0);
      v.br  = ($urandom_range(7) == 0);
      drive(v);
    end

    // saturation: continuous load-use stall
    v = idle(); v.rst = 1; drive(v);
    v = idle(); v.emr = 1; v.erd = 7; v.urt = 1; v.rt = 7;
    for (int i = 0; i < 65540; i++) drive(v);
    drive(idle()); drive(idle());

    @(negedge clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
